// File: rtl/wb2av.sv
// wb2av: Wishbone B4 pipelined slave to Avalon-MM pipelined master bridge.
// Define WB2AV_CMD_REG_EN to insert a one-entry command register (+1 cycle).
module wb2av #(
  parameter int AW              = 32,
  parameter int DW              = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_adr,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel,
  output logic            wb_stall,
  output logic            wb_ack,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_err,
  output logic            wb_rty,
  output logic [AW-1:0]   av_address,
  output logic [DW/8-1:0] av_byteenable,
  output logic            av_read,
  output logic            av_write,
  output logic [DW-1:0]   av_writedata,
  input  logic            av_waitrequest,
  input  logic [DW-1:0]   av_readdata,
  input  logic            av_readdatavalid
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LASTP) ? '0 : p + 1'b1;
  endfunction

  logic [MAX_OUTSTANDING-1:0] ord_q, ord_d;
  logic [PW-1:0]              owp_q, owp_d;
  logic [PW-1:0]              orp_q, orp_d;
  logic [CW-1:0]              ocnt_q, ocnt_d;

  logic [DW-1:0]              rmem_q [MAX_OUTSTANDING];
  logic [PW-1:0]              rwp_q, rwp_d;
  logic [PW-1:0]              rrp_q, rrp_d;
  logic [CW-1:0]              rcnt_q, rcnt_d;

  logic                       draining_q, draining_d;
  logic                       ack_q, ack_d;
  logic [DW-1:0]              dat_q, dat_d;

  logic          full;
  logic          pend_cmd;
  logic          push;
  logic          push_rd;
  logic          pop;
  logic          pop_rd;
  logic          head_vld;
  logic          head_rd;
  logic          rd_avail;
  logic          drain_set;
  logic          drain_clr;
  logic          discard;
  logic [DW-1:0] rd_head;

  assign wb_err   = 1'b0;
  assign wb_rty   = 1'b0;
  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_q;

`ifdef WB2AV_CMD_REG_EN
  logic            creg_v_q, creg_v_d;
  logic            creg_we_q;
  logic [AW-1:0]   creg_adr_q;
  logic [DW-1:0]   creg_dat_q;
  logic [DW/8-1:0] creg_sel_q;
  logic            wb_acc;
  logic [CW:0]     occ;

  // The held command already owns an ordering slot.
  assign occ      = {1'b0, ocnt_q} + {{CW{1'b0}}, creg_v_q};
  assign full     = (occ >= {1'b0, MAXC});
  assign pend_cmd = creg_v_q;

  assign wb_stall = full | draining_q |
                    (creg_v_q & av_waitrequest);
  assign wb_acc   = wb_cyc & wb_stb & ~wb_stall;

  assign av_read       = creg_v_q & ~creg_we_q;
  assign av_write      = creg_v_q & creg_we_q;
  assign av_address    = creg_adr_q;
  assign av_byteenable = creg_sel_q;
  assign av_writedata  = creg_dat_q;

  always_comb begin
    creg_v_d = creg_v_q;
    if (wb_acc) begin
      creg_v_d = 1'b1;
    end else if (!av_waitrequest) begin
      creg_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      creg_v_q   <= 1'b0;
      creg_we_q  <= 1'b0;
      creg_adr_q <= '0;
      creg_dat_q <= '0;
      creg_sel_q <= '0;
    end else begin
      creg_v_q <= creg_v_d;
      if (wb_acc) begin
        creg_we_q  <= wb_we;
        creg_adr_q <= wb_adr;
        creg_dat_q <= wb_dat_i;
        creg_sel_q <= wb_sel;
      end
    end
  end
`else
  assign full     = (ocnt_q == MAXC);
  assign pend_cmd = 1'b0;

  assign av_read  = wb_cyc & wb_stb & ~wb_we &
                    ~full & ~draining_q;
  assign av_write = wb_cyc & wb_stb & wb_we &
                    ~full & ~draining_q;
  assign wb_stall = full | draining_q | av_waitrequest;

  assign av_address    = wb_adr;
  assign av_byteenable = wb_sel;
  assign av_writedata  = wb_dat_i;
`endif

  assign push    = (av_read | av_write) & ~av_waitrequest;
  assign push_rd = av_read & ~av_waitrequest;

  // Empty FIFOs forward this cycle's entry so acks land one cycle later.
  assign head_vld = (ocnt_q != '0) | push;
  assign head_rd  = (ocnt_q != '0) ? ord_q[orp_q] : push_rd;
  assign rd_avail = (rcnt_q != '0) | av_readdatavalid;
  assign rd_head  = (rcnt_q != '0) ? rmem_q[rrp_q] : av_readdata;

  assign pop    = head_vld & (~head_rd | rd_avail);
  assign pop_rd = pop & head_rd;

  assign drain_set = ~wb_cyc & ((ocnt_q != '0) | pend_cmd);
  assign drain_clr = (ocnt_q == '0) & (rcnt_q == '0) & ~pend_cmd;
  assign discard   = draining_q | drain_set;

  always_comb begin
    ord_d      = ord_q;
    owp_d      = owp_q;
    orp_d      = orp_q;
    ocnt_d     = ocnt_q;
    rwp_d      = rwp_q;
    rrp_d      = rrp_q;
    rcnt_d     = rcnt_q;
    draining_d = drain_set | (draining_q & ~drain_clr);
    ack_d      = pop & ~discard;
    dat_d      = pop_rd ? rd_head : '0;

    if (push) begin
      ord_d[owp_q] = push_rd;
      owp_d        = nxt(owp_q);
    end
    if (pop) begin
      orp_d = nxt(orp_q);
    end
    unique case ({push, pop})
      2'b10:   ocnt_d = ocnt_q + 1'b1;
      2'b01:   ocnt_d = ocnt_q - 1'b1;
      default: ocnt_d = ocnt_q;
    endcase

    if (av_readdatavalid) begin
      rwp_d = nxt(rwp_q);
    end
    if (pop_rd) begin
      rrp_d = nxt(rrp_q);
    end
    unique case ({av_readdatavalid, pop_rd})
      2'b10:   rcnt_d = rcnt_q + 1'b1;
      2'b01:   rcnt_d = rcnt_q - 1'b1;
      default: rcnt_d = rcnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_q      <= '0;
      owp_q      <= '0;
      orp_q      <= '0;
      ocnt_q     <= '0;
      rwp_q      <= '0;
      rrp_q      <= '0;
      rcnt_q     <= '0;
      draining_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      ord_q      <= ord_d;
      owp_q      <= owp_d;
      orp_q      <= orp_d;
      ocnt_q     <= ocnt_d;
      rwp_q      <= rwp_d;
      rrp_q      <= rrp_d;
      rcnt_q     <= rcnt_d;
      draining_q <= draining_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        rmem_q[i] <= '0;
      end
    end else if (av_readdatavalid) begin
      rmem_q[rwp_q] <= av_readdata;
    end
  end

endmodule

// File: doc/wb2av.md
# wb2av

Wishbone B4 pipelined slave to Avalon-MM pipelined master bridge: the return path for fabrics where a Wishbone initiator drives Avalon-MM peripherals. Each accepted Wishbone request becomes one Avalon read or write. Avalon `readdatavalid` responses are matched back to Wishbone `ack`s in strict issue order, with up to MAX_OUTSTANDING transactions in flight.

## Interface
- AW, 32, address width.
- DW, 64, data width; must be a multiple of 8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged transactions; must be ≥1.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wb_cyc, wb_stb, wb_we  in  1  Wishbone cycle, strobe and write enable.
- wb_adr  in  AW  address.
- wb_dat_i  in  DW  write data.
- wb_sel  in  DW/8  byte selects.
- wb_stall  out  1  request not accepted this cycle.
- wb_ack  out  1  transaction complete.
- wb_dat_o  out  DW  read data; valid with `wb_ack` on reads.
- wb_err, wb_rty  out  1  constant 0.
- av_address  out  AW  Avalon address, copied from `wb_adr`.
- av_byteenable  out  DW/8  copied from `wb_sel`.
- av_read, av_write  out  1  Avalon command strobes.
- av_writedata  out  DW  copied from `wb_dat_i`.
- av_waitrequest  in  1  slave not accepting the command.
- av_readdata  in  DW  read data.
- av_readdatavalid  in  1  read data valid.

## Operation
- **Ordering queue:** an order FIFO of depth MAX_OUTSTANDING holds one type bit per issued command (0 = write, 1 = read).
  - A push happens when the Avalon command is accepted: (`av_read` or `av_write`) and !`av_waitrequest`.
  - `full` means the FIFO holds MAX_OUTSTANDING entries.
- **Read data FIFO:** depth MAX_OUTSTANDING.
  - Pushed on every `av_readdatavalid`, capturing `av_readdata`.
  - It can never overflow, because reads in flight ≤ MAX_OUTSTANDING.
- **Command path (default):**
  - `av_read` = `wb_cyc` & `wb_stb` & !`wb_we` & !`full` & !`draining`.
  - `av_write` is the same expression with `wb_we` in place of !`wb_we`.
  - `wb_stall` = `full` | `draining` | `av_waitrequest`.
  - A Wishbone accept and an Avalon accept are the same event.
- **Ack engine:** at most one pop per cycle.
  - If the head entry is a write: pop it.
  - If the head entry is a read and the read data FIFO is non-empty: pop both.
  - Registered outputs: `wb_ack` <= pop & !`discard`; `wb_dat_o` <= popped read data on a read pop, else 0.
- **Outstanding count:** width $clog2(MAX_OUTSTANDING+1). +1 on push, -1 on pop, unchanged when both or neither happen.
- **Abort:** when `wb_cyc` is low and the order FIFO is non-empty, set `draining` and `discard`.
  - While `discard` is set, pops still occur but `wb_ack` stays 0.
  - Late `av_readdatavalid` beats are absorbed normally.
  - `draining` and `discard` clear once both FIFOs are empty.
  - A new `wb_cyc` during draining sees `wb_stall` = 1.
- **Reset:** all registers clear asynchronously. Reset mid-transaction drops all pending state; Avalon responses that arrive after reset are outside the spec.

## Timing
- Reset values:
  - `wb_ack` = 0, `wb_dat_o` = 0, `wb_err` = 0, `wb_rty` = 0.
  - `av_read` = 0, `av_write` = 0; `wb_stall` = `av_waitrequest`.
  - count = 0, FIFOs empty, `draining` = 0.
- Write: Avalon accept in cycle N gives `wb_ack` in N+1 when no older entry is pending.
- Read: `av_readdatavalid` in cycle M gives `wb_ack` with data in M+1 when the read is at the head.
- Throughput: one accept and one ack per cycle sustained.
- Simultaneous push and pop when `full`: the push is blocked, because `full` is evaluated before the pop.
- FIFO pointers wrap modulo MAX_OUTSTANDING; occupancy is tracked by count, not by pointer compare.

## Configuration
- **WB2AV_CMD_REG_EN defined:** a one-entry command register sits between Wishbone and Avalon.
  - Wishbone accepts when the register is empty or its command is being accepted by Avalon.
  - Avalon outputs come from the register, adding 1 cycle of command latency.
  - `wb_stall` = `full` | `draining` | (reg_valid & `av_waitrequest`).
  - `full` counts the registered entry.
- **Not defined:** the combinational command path described in Operation.

## Test plan
- Single write, adr=0x10, dat=0xA5, sel=0xFF, no wait: `av_write` pulses 1 cycle with identical fields; `wb_ack` one cycle later.
- Single read, `av_readdatavalid` 3 cycles after accept, data 0x1234: `wb_ack` with `wb_dat_o` = 0x1234 one cycle after `readdatavalid`.
- Read, write, read issued back to back, both read latencies 4: acks arrive in order read, write, read; the write ack waits for the first read.
- Five pipelined reads with MAX_OUTSTANDING=4 and no responses: `wb_stall` rises on the 5th request; the 5th is accepted the cycle after the first `wb_ack` pop.
- `av_waitrequest` held 3 cycles on a write: `wb_stall` high for 3 cycles; exactly one Avalon write accepted.
- `wb_cyc` dropped with 2 reads outstanding: no `wb_ack` for either; both `readdatavalid` beats absorbed; a new cycle stalls until the FIFOs empty, then completes normally.
